// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and helpers for the sequential N x M multiplier.
//               Holds the FSM state encoding and a counter-width function.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

   // FSM state encoding, fixed so that state values are stable across tools
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Number of bits needed to count 0..value-1 (never less than one bit)
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_seq_nxm_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_nxm_if
// Description : Operand / result handshake bundle of the sequential multiplier.
//               master = producer/consumer side, slave = multiplier side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_seq_nxm_if #(
   parameter int N = 8,
   parameter int M = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     a;
   logic [M-1:0]     b;
   logic             sgn;
   logic             out_valid;
   logic             out_ready;
   logic [N+M-1:0]   y;

   modport master (
      output in_valid,
      output a,
      output b,
      output sgn,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  y
   );

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  sgn,
      input  out_ready,
      output in_ready,
      output out_valid,
      output y
   );
endinterface : mult_seq_nxm_if
`default_nettype wire

// File: rtl/mult_seq_nxm_addsub.sv
`default_nettype none
// ============================================================================
// Module      : addsub_w
// Description : Combinational W-bit adder/subtractor. sub=1 gives x-z,
//               sub=0 gives x+z; result wraps modulo 2**W.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_w #(
   parameter int W = 8
) (
   input  wire logic [W-1:0] x,
   input  wire logic [W-1:0] z,
   input  wire logic         sub,
   output logic      [W-1:0] sum
);

   // Single add/subtract shared by every accumulation step
   always_comb begin
      sum = '0;
      if (sub) begin
         sum = x - z;
      end else begin
         sum = x + z;
      end
   end

endmodule : addsub_w
`default_nettype wire

// File: rtl/mult_seq_nxm.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_nxm
// Description : Sequential radix-2 shift-and-add multiplier, N-bit a by M-bit
//               b, unsigned or two's-complement, one multiplier bit per cycle.
//               Result is the full N+M-bit product, valid M edges after accept.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_seq_nxm
   import mult_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 8
) (
   input  wire logic          clk,
   input  wire logic          rst,
   mult_seq_nxm_if.slave      bus
);

   // One guard bit above the product keeps the signed subtract step exact
   localparam int C_ACC_W = N + M + 1;
   localparam int C_CNT_W = clog2(M);

   state_e               state_q, state_d;
   logic [N-1:0]         a_q, a_d;
   logic [M-1:0]         b_q, b_d;
   logic                 sgn_q, sgn_d;
   logic [C_CNT_W-1:0]   cnt_q, cnt_d;
   logic [C_ACC_W-1:0]   acc_q, acc_d;

   logic                 w_last;
   logic                 w_bit;
   logic                 w_sub;
   logic [C_ACC_W-1:0]   w_ext_a;
   logic [C_ACC_W-1:0]   w_addend;
   logic [C_ACC_W-1:0]   w_sum;
   logic                 w_unused_guard;

   // Current multiplier bit and whether it is the sign-weighted top bit
   assign w_last = (cnt_q == C_CNT_W'(M - 1));
   assign w_bit  = b_q[cnt_q];

   // Multiplicand extended to accumulator width, aligned at the current bit
   always_comb begin
      w_ext_a  = '0;
      w_addend = '0;
      if (sgn_q) begin
         w_ext_a = {{(M + 1){a_q[N-1]}}, a_q};
      end else begin
         w_ext_a = {{(M + 1){1'b0}}, a_q};
      end
      if (w_bit) begin
         w_addend = w_ext_a << cnt_q;
      end
   end

   // In signed mode the top multiplier bit carries weight -2**(M-1)
   assign w_sub = sgn_q & w_last;

   addsub_w #(
      .W (C_ACC_W)
   ) u_addsub (
      .x   (acc_q),
      .z   (w_addend),
      .sub (w_sub),
      .sum (w_sum)
   );

   // State, operand, counter and accumulator registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
      end
   end

   // Next-state logic: accept in IDLE, one bit per edge in BUSY, hold in DONE
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               sgn_d   = bus.sgn;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            acc_d = w_sum;
            if (w_last) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + C_CNT_W'(1);
            end
         end
         DONE: begin
            // Result drains back to IDLE; a new accept needs a later edge
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake outputs are pure decodes of the state register
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.y         = acc_q[N+M-1:0];

   // Guard bit only matters for intermediate sums, never for the product
   assign w_unused_guard = acc_q[C_ACC_W-1];

endmodule : mult_seq_nxm
`default_nettype wire

// File: doc/mult_seq_nxm.md
MULT_SEQ_NXM -- requirements
Module: mult_seq_nxm

Interface
REQ-001 Parameter: N, 8, multiplicand (a) width in bits; SHALL be >= 2.
REQ-002 Parameter: M, 8, multiplier (b) width in bits; SHALL be >= 2; also the iteration count.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: in_valid  input  1  operands and mode presented.
REQ-006 Port: in_ready  output  1  block can accept an operation.
REQ-007 Port: a  input  N  multiplicand.
REQ-008 Port: b  input  M  multiplier.
REQ-009 Port: sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
REQ-010 Port: out_valid  output  1  product y valid.
REQ-011 Port: out_ready  input  1  consumer accepts y.
REQ-012 Port: y  output  N+M  product; full width, never overflows.

Function
REQ-013 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE: on an edge with in_valid=1, the block SHALL register a, b and sgn, clear the accumulator and bit counter, and enter BUSY.
REQ-015 BUSY: each edge SHALL process one multiplier bit, LSB first, using shift-and-add radix-2, with the counter counting 0..M-1.
REQ-016 Unsigned step: if b[i]=1, add a zero-extended a, aligned at bit i.
REQ-017 Signed step, i < M-1: if b[i]=1, add a sign-extended a at bit i.
REQ-018 Signed step, i = M-1: if b[M-1]=1, subtract a sign-extended a at bit M-1 (multiplier sign weight).
REQ-019 Accumulator SHALL be N+M+1 bits internally; y SHALL be its low N+M bits.
REQ-020 On the edge processing bit M-1, the FSM SHALL enter DONE with y final; latency is exactly M edges from the accept edge to out_valid=1.
REQ-021 DONE: y and out_valid SHALL hold stable until an edge with out_ready=1, which SHALL return the FSM to IDLE; no accept occurs in that same cycle. Throughput is one operation per M+2 cycles at best.
REQ-022 in_valid, a, b and sgn changes outside an accept edge SHALL have no effect; in_valid asserted during BUSY or DONE SHALL be ignored, not queued.
REQ-023 Boundaries: a=0 or b=0 SHALL yield y=0; signed most-negative × most-negative SHALL yield the exact positive result (N=M=4: -8 × -8 = 64).
REQ-024 out_ready asserted while not in DONE SHALL have no effect.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, in_ready=1 (after release), out_valid=0, y=0, and clear the counter and operand registers.
REQ-026 Reset asserted mid-BUSY or in DONE SHALL abort the operation with no output produced; the first accept after release SHALL behave as from power-up.

Structure
REQ-027 The shared package mult_pkg SHALL hold the FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and a counter-width function clog2.
REQ-028 The add/subtract datapath SHALL be one combinational sub-module, addsub_w, parametrised by width W, with ports x, z, sub and sum; sub=1 SHALL compute x-z.
REQ-029 FSM, counter, operand registers and accumulator SHALL reside in mult_seq_nxm; target 120-400 lines of RTL.

Verification
REQ-030 Use N=M=4, sgn=0, a=15, b=15, accept at edge 0 -> out_valid at edge 4, y=8'hE1 (225).
REQ-031 Use sgn=1, a=4'hF (-1), b=4'h7 -> y=8'hF9 (-7); then a=4'h8, b=4'h8 -> y=8'h40 (64).
REQ-032 Hold out_ready=0 for 3 cycles in DONE with y=8'h2A -> y and out_valid stable; in_ready stays 0; out_ready=1 -> IDLE next edge.
REQ-033 Pulse in_valid with a=3, b=5 at BUSY edge 2 of a 6×7 op -> result 42 unaffected; no second result.
REQ-034 Assert rst at BUSY edge 2 -> out_valid=0, y=0, in_ready=1 after release; next op 2×3 -> y=6 after 4 edges.
REQ-035 Random regression, N=8, M=5, both sgn, against a reference model: y matches, and latency is M on every op.
